// File: rtl/id_queue.sv
// Decode-stage instruction queue: a DEPTH-entry circular buffer between fetch
// and decode that classifies each instruction at push time.
module id_queue #(
  parameter int DEPTH = 2,
  parameter int RI_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  input  logic [4:0]                 in_excode,
  input  logic                       in_bd,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                IR_D,
  output logic [31:0]                PC_D,
  output logic [31:0]                PC4_D,
  output logic [31:0]                PC8_D,
  output logic [4:0]                 excode_D,
  output logic                       bd_D,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [4:0] EXC_RI = 5'd10;

  logic [31:0] instr_q  [DEPTH];
  logic [31:0] pc_q     [DEPTH];
  logic [4:0]  excode_q [DEPTH];
  logic        bd_q     [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;

  logic        push;
  logic        pop;
  logic [31:0] st_instr;
  logic [4:0]  st_excode;

  function automatic logic supported(input logic [31:0] w);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       ok;
    op    = w[31:26];
    rs    = w[25:21];
    rt    = w[20:16];
    funct = w[5:0];
    ok    = 1'b0;
    if (op == 6'h00) begin
      ok = funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                         6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                         [6'h20:6'h27], 6'h2A, 6'h2B};
    end else if (op == 6'h01) begin
      ok = (rt == 5'h00) || (rt == 5'h01);
    end else if (op inside {[6'h02:6'h0F]}) begin
      ok = 1'b1;
    end else if (op == 6'h10) begin
      ok = (rs == 5'h00) || (rs == 5'h04) || (w == 32'h4200_0018);
    end else begin
      ok = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    end
    return ok;
  endfunction

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush and reset suppress the handshakes so they win over any concurrent traffic.
  assign push = in_valid && in_ready && !flush && !reset;
  assign pop  = out_valid && out_ready && !flush && !reset;

  // A fetch exception takes precedence and turns the stored word into a nop.
  always_comb begin
    st_instr  = in_instr;
    st_excode = '0;
    if (in_excode != '0) begin
      st_excode = in_excode;
      st_instr  = '0;
    end else if ((RI_EN != 0) && !supported(in_instr)) begin
      st_excode = EXC_RI;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr]  <= st_instr;
      pc_q[wr_ptr]     <= in_pc;
      excode_q[wr_ptr] <= st_excode;
      bd_q[wr_ptr]     <= in_bd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    IR_D     = '0;
    PC_D     = '0;
    PC4_D    = '0;
    PC8_D    = '0;
    excode_D = '0;
    bd_D     = 1'b0;
    if (out_valid) begin
      IR_D     = instr_q[rd_ptr];
      PC_D     = pc_q[rd_ptr];
      PC4_D    = pc_q[rd_ptr] + 32'd4;
      PC8_D    = pc_q[rd_ptr] + 32'd8;
      excode_D = excode_q[rd_ptr];
      bd_D     = bd_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_id_queue.sv
// Scoreboard bench for id_queue: the driver records accepted entries, a
// negedge monitor compares every popped head against them.
module tb_id_queue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_excode;
  logic        in_bd;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, bd_D;
  logic [31:0] IR_D, PC_D, PC4_D, PC8_D;
  logic [4:0]  excode_D;
  logic [$clog2(DEPTH):0] count;

  logic        in_ready0, out_valid0, bd_D0;
  logic [31:0] IR_D0, PC_D0, PC4_D0, PC8_D0;
  logic [4:0]  excode_D0;
  logic [$clog2(DEPTH):0] count0;

  id_queue #(.DEPTH(DEPTH), .RI_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_excode(in_excode), .in_bd(in_bd),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .IR_D(IR_D), .PC_D(PC_D), .PC4_D(PC4_D), .PC8_D(PC8_D),
    .excode_D(excode_D), .bd_D(bd_D), .count(count)
  );

  id_queue #(.DEPTH(DEPTH), .RI_EN(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .in_excode(in_excode), .in_bd(in_bd),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid0),
    .IR_D(IR_D0), .PC_D(PC_D0), .PC4_D(PC4_D0), .PC8_D(PC8_D0),
    .excode_D(excode_D0), .bd_D(bd_D0), .count(count0)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic [4:0]  exc0;
    logic        bd;
  } ent_t;

  ent_t sb[$];
  int   mcount;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      ent_t e;
      chk("count", 32'(count), 32'(mcount));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("in_ready0", 32'(in_ready0), 32'(mcount < DEPTH));
      if (mcount == 0) begin
        chk("empty_ir", IR_D, 32'h0);
        chk("empty_pc", PC_D, 32'h0);
        chk("empty_pc8", PC8_D, 32'h0);
        chk("empty_exc", 32'(excode_D), 32'h0);
        chk("empty_bd", 32'(bd_D), 32'h0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", IR_D, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("IR_D", IR_D, e.instr);
          chk("PC_D", PC_D, e.pc);
          chk("PC4_D", PC4_D, e.pc + 32'd4);
          chk("PC8_D", PC8_D, e.pc + 32'd8);
          chk("excode_D", 32'(excode_D), 32'(e.exc));
          chk("bd_D", 32'(bd_D), 32'(e.bd));
          chk("IR_D_ri0", IR_D0, e.instr);
          chk("excode_D_ri0", 32'(excode_D0), 32'(e.exc0));
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic [4:0] exc, input logic b, input logic ordy,
                       input logic fl, input logic [31:0] ew, input logic [4:0] ee);
    logic acc, pp;
    ent_t e;
    in_valid = v; in_instr = w; in_pc = pc; in_excode = exc; in_bd = b;
    out_ready = ordy; flush = fl;
    chk("in_ready", 32'(in_ready), 32'(mcount < DEPTH));
    acc = v && !fl && (mcount < DEPTH);
    pp  = ordy && !fl && (mcount > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      mcount = 0;
      sb.delete();
    end else begin
      mcount = mcount + int'(acc) - int'(pp);
      if (acc) begin
        e.instr = ew; e.pc = pc; e.exc = ee; e.exc0 = exc; e.bd = b;
        sb.push_back(e);
      end
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, ordy, 1'b0, 32'h0, 5'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mcount = 0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_excode = '0;
    in_bd = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ir", IR_D, 32'h0);
    chk("rst_exc", 32'(excode_D), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_pc4", PC4_D, 32'h0);

    // fill with decode stalled, third offer refused
    cycle(1, 32'h3408_0001, 32'h3000, 0, 0, 0, 0, 32'h3408_0001, 0);
    cycle(1, 32'h0000_0000, 32'h3004, 0, 0, 0, 0, 32'h0000_0000, 0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_ir", IR_D, 32'h3408_0001);
    chk("full_pc4", PC4_D, 32'h3004);
    chk("full_pc8", PC8_D, 32'h3008);
    cycle(1, 32'h8C09_0000, 32'h3008, 0, 0, 0, 0, 32'h8C09_0000, 0);
    chk("stall_ir", IR_D, 32'h3408_0001);
    idle(1); idle(1);
    chk("drained_count", 32'(count), 32'h0);

    // simultaneous push/pop at count=1, long enough to wrap the pointers
    cycle(1, 32'h2400_0100, 32'h4000, 0, 0, 0, 0, 32'h2400_0100, 0);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      cycle(1, 32'h2400_0000 + 32'(i), 32'h4004 + 32'(4 * i), 0, 0, 1, 0,
            32'h2400_0000 + 32'(i), 0);
      chk("pp_count", 32'(count), 32'h1);
      chk("pp_head", IR_D, 32'h2400_0000 + 32'(i));
    end
    idle(1);

    // classification, flowing straight through
    cycle(1, 32'hFC00_0000, 32'h5000, 0, 0, 1, 0, 32'hFC00_0000, 5'd10);
    cycle(1, 32'h4200_0018, 32'h5004, 0, 0, 1, 0, 32'h4200_0018, 5'd0);
    cycle(1, 32'h0000_000C, 32'h5008, 0, 0, 1, 0, 32'h0000_000C, 5'd10);
    cycle(1, 32'h8C09_0000, 32'h500C, 4, 0, 1, 0, 32'h0000_0000, 5'd4);
    cycle(1, 32'h0000_000D, 32'h5010, 0, 0, 1, 0, 32'h0000_000D, 5'd10);
    cycle(1, 32'h0402_0000, 32'h5014, 0, 0, 1, 0, 32'h0402_0000, 5'd10);
    cycle(1, 32'h0401_0005, 32'h5018, 0, 0, 1, 0, 32'h0401_0005, 5'd0);
    cycle(1, 32'h4088_0000, 32'h501C, 0, 0, 1, 0, 32'h4088_0000, 5'd0);
    cycle(1, 32'h4040_0000, 32'h5020, 0, 0, 1, 0, 32'h4040_0000, 5'd10);
    cycle(1, 32'h8C09_0000, 32'h5024, 0, 0, 1, 0, 32'h8C09_0000, 5'd0);
    cycle(1, 32'h8800_0000, 32'h5028, 0, 0, 1, 0, 32'h8800_0000, 5'd10);
    cycle(1, 32'h0109_4821, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h0109_4821, 5'd0);
    idle(1);

    // flush beats a concurrent offer, both when full and when not
    cycle(1, 32'h2401_0001, 32'h6000, 0, 0, 0, 0, 32'h2401_0001, 0);
    cycle(1, 32'h2401_0002, 32'h6004, 0, 0, 0, 0, 32'h2401_0002, 0);
    cycle(1, 32'h2401_0003, 32'h6008, 0, 0, 0, 1, 32'h2401_0003, 0);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    cycle(1, 32'h2401_0004, 32'h600C, 0, 0, 0, 0, 32'h2401_0004, 0);
    cycle(1, 32'h2401_0005, 32'h6010, 0, 0, 1, 1, 32'h2401_0005, 0);
    idle(1); idle(1);

    // delay-slot flag follows its entry
    cycle(1, 32'h1109_0003, 32'h7000, 0, 0, 0, 0, 32'h1109_0003, 0);
    cycle(1, 32'h0000_0000, 32'h7004, 0, 1, 0, 0, 32'h0000_0000, 0);
    idle(1); idle(1);

    // reset mid-operation
    cycle(1, 32'h2401_0006, 32'h8000, 0, 0, 0, 0, 32'h2401_0006, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mcount = 0;
    sb.delete();
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ir", IR_D, 32'h0);
    idle(1);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
